audio_tone_sequencer: RTL and testbench
=======================================

Name: audio_tone_sequencer

Overview:
- Programmable step sequencer that drives the shared 16-bit counter-based audio tone datapath.
- Holds a small pattern of (phase increment, duration) steps.
- Walks the pattern at a fixed tick rate and presents per-step increment and gate to the tone counter.
- Sits between the control/config logic and the audio_out counter; provides start/stop/loop sequencing and completion status.

Parameters:
- STEPS, 16, number of pattern entries (power of two); index width SW = log2(STEPS).
- TICK_DIV, 25175, clk cycles per duration tick (1 kHz at 25.175 MHz); minimum 2.
- GAP_TICKS, 1, silent ticks inserted after every played step; 0 disables the gap.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- cfg_we  input  1  pattern write strobe.
- cfg_addr  input  SW  pattern entry index.
- cfg_data  input  24  [23:8] phase increment, [7:0] duration in ticks.
- start  input  1  one-cycle request to begin playback at step 0.
- stop  input  1  one-cycle request to abort playback.
- loop_en  input  1  restart at step 0 on end-of-pattern instead of finishing.
- busy  output  1  high in every state except IDLE.
- step_idx  output  SW  index of the step currently loaded/playing.
- tone_inc  output  16  increment presented to the tone counter.
- tone_en  output  1  gate for the tone counter.
- step_strobe  output  1  one-cycle pulse when a new step begins playing.
- done  output  1  one-cycle pulse on natural end of a non-looping pattern.

Behaviour:
- Reset:
  - Outputs: busy=0, step_idx=0, tone_inc=0, tone_en=0, step_strobe=0, done=0.
  - State IDLE; tick prescaler and duration counter cleared.
  - Pattern RAM is not cleared by reset.
- Pattern RAM:
  - STEPS x 24 flops; write on cfg_we, takes effect next cycle; writable in any state.
  - A write to the currently playing step affects only its next LOAD.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - start=1 -> LOAD next cycle with step_idx=0.
  - stop ignored.
- LOAD (exactly 1 cycle): read entry[step_idx].
  - dur != 0:
    - latch tone_inc=inc and duration counter=dur; clear prescaler.
    - tone_en=(inc!=0); an increment of 0 is a rest.
    - pulse step_strobe; enter PLAY.
  - dur == 0 (end marker):
    - loop_en=1 and step_idx!=0 -> step_idx=0, stay in LOAD.
    - otherwise -> pulse done, tone_en=0, enter IDLE.
    - An all-zero step 0 therefore finishes even when loop_en=1; this prevents an infinite zero-length loop.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1; each wrap decrements the duration counter.
  - When the counter reaches 0: tone_en=0, then GAP (GAP_TICKS>0) or advance.
  - PLAY lasts exactly dur*TICK_DIV cycles.
- GAP:
  - tone_en=0, tone_inc held; lasts GAP_TICKS*TICK_DIV cycles, then advance.
- Advance:
  - step_idx+1, then LOAD.
  - Completing step STEPS-1 wraps step_idx to 0 and acts as an end marker: if loop_en=1 -> LOAD step 0, else pulse done and go to IDLE.
  - done pulses in the cycle the state returns to IDLE.
- loop_en is sampled only at the end-of-pattern decision.
- stop:
  - Any non-IDLE state -> IDLE next cycle.
  - tone_en=0 and tone_inc=0 next cycle; step_idx=0; done not pulsed.
- Priorities:
  - start while busy is ignored.
  - start and stop in the same cycle in IDLE: stop wins, stay IDLE.
  - rst overrides everything, including mid-PLAY.
- Output timing:
  - All outputs are registered.
  - step_strobe and the new tone_inc/tone_en appear in the same cycle (first PLAY cycle).

Test Plan (TICK_DIV=4, GAP_TICKS=1 unless noted):
- Single note:
  - Stimulus: write step0=(0x0100,3), step1=(0,0); pulse start.
  - Required: busy rises next cycle; step_strobe at cycle 2; tone_inc=0x0100 and tone_en=1 for exactly 12 cycles; then 4 gap cycles with tone_en=0; then done pulses once and busy=0.
- Rest and sequence:
  - Stimulus: step0=(0x0200,1), step1=(0,2), step2=(0x0300,1), step3 end marker.
  - Required: step_strobe pulses 3 times; tone_en low for the step1 play window (8 cycles) while step_idx=1; tone_inc shows 0x0300 on step 2.
- Loop and wrap:
  - Stimulus: fill all 16 steps with dur=1; loop_en=1; run.
  - Required: step_idx wraps 15 -> 0 without done; clearing loop_en then yields done after step 15.
- Stop mid-note:
  - Stimulus: pulse stop 5 cycles into PLAY.
  - Required: next cycle busy=0, tone_en=0, tone_inc=0, step_idx=0, no done pulse; a following start replays from step 0.
- Collisions:
  - start+stop in the same cycle in IDLE -> stays IDLE.
  - start during PLAY -> no effect.
  - All-zero step0 with loop_en=1 -> done two cycles after start.
- Reset mid-operation:
  - Stimulus: assert rst during GAP.
  - Required: all outputs 0 next cycle; previously written pattern still plays correctly after start.

Source files
------------

// File: rtl/audio_tone_sequencer.sv
// Step sequencer for the shared 16-bit tone counter: walks a pattern of
// (phase increment, duration) entries and drives increment, gate and status.
module audio_tone_sequencer #(
    parameter int STEPS     = 16,
    parameter int TICK_DIV  = 25175,
    parameter int GAP_TICKS = 1,
    localparam int SW       = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_addr,
    input  logic [23:0]   cfg_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic          busy,
    output logic [SW-1:0] step_idx,
    output logic [15:0]   tone_inc,
    output logic          tone_en,
    output logic          step_strobe,
    output logic          done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [15:0]   inc_q, inc_d;
    logic          en_q, en_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   pattern [STEPS];
    logic [23:0]   entry;
    logic          tick_wrap;
    logic          advance;

    // Pattern storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            pattern[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        inc_d     = inc_q;
        en_d      = en_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        advance   = 1'b0;
        entry     = pattern[idx_q];
        tick_wrap = (presc_q == PW'(TICK_DIV - 1));

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (entry[7:0] != 8'd0) begin
                    inc_d    = entry[23:8];
                    en_d     = (entry[23:8] != 16'd0);
                    cnt_d    = CW'(entry[7:0]);
                    presc_d  = '0;
                    strobe_d = 1'b1;
                    state_d  = PLAY;
                end else if (loop_en && idx_q != '0) begin
                    idx_d = '0;
                end else begin
                    done_d  = 1'b1;
                    en_d    = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            PLAY, GAP: begin
                presc_d = tick_wrap ? '0 : presc_q + PW'(1);
                if (tick_wrap) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        en_d = 1'b0;
                        if (state_q == PLAY && GAP_TICKS > 0) begin
                            state_d = GAP;
                            cnt_d   = CW'(GAP_TICKS);
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Finishing the last slot behaves like hitting an end marker.
        if (advance) begin
            if (idx_q == SW'(STEPS - 1) && !loop_en) begin
                state_d = IDLE;
                done_d  = 1'b1;
                idx_d   = '0;
            end else begin
                state_d = LOAD;
                idx_d   = idx_q + SW'(1);
            end
        end

        if (stop && state_q != IDLE) begin
            state_d  = IDLE;
            idx_d    = '0;
            inc_d    = 16'd0;
            en_d     = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            inc_q    <= 16'd0;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            inc_q    <= inc_d;
            en_q     <= en_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign step_idx    = idx_q;
    assign tone_inc    = inc_q;
    assign tone_en     = en_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Self-checking bench for audio_tone_sequencer: a timeline model expands the
// written pattern into the expected per-cycle outputs and each test compares.
module tb_audio_tone_sequencer;

    localparam int TD   = 4;
    localparam int GAPT = 1;
    localparam int NS   = 16;
    localparam logic [23:0] IDXM = 24'h780000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        busy;
    logic [3:0]  step_idx;
    logic [15:0] tone_inc;
    logic        tone_en;
    logic        step_strobe;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] pat_inc [NS];
    logic [7:0]  pat_dur [NS];
    logic [23:0] exp_q [$];
    logic [23:0] msk_q [$];
    logic [15:0] cur_inc;

    always #5 clk = ~clk;

    audio_tone_sequencer #(.STEPS(NS), .TICK_DIV(TD), .GAP_TICKS(GAPT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .stop(stop), .loop_en(loop_en),
        .busy(busy), .step_idx(step_idx), .tone_inc(tone_inc),
        .tone_en(tone_en), .step_strobe(step_strobe), .done(done)
    );

    function automatic logic [23:0] obs();
        return {busy, step_idx, tone_inc, tone_en, step_strobe, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int a, input logic [15:0] inc, input logic [7:0] dur);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = {inc, dur};
        tick();
        cfg_we     = 1'b0;
        pat_inc[a] = inc;
        pat_dur[a] = dur;
    endtask

    // Timeline from the pattern: entry i is cycle i+1 after the start cycle.
    // loop_en is treated as 1 for decisions made in cycles below clr.
    function automatic void build_trace(input int clr);
        int          idx = 0;
        logic [15:0] inc = cur_inc;
        exp_q.delete();
        msk_q.delete();
        while (exp_q.size() < 4000) begin
            exp_q.push_back({1'b1, 4'(idx), inc, 3'b000});
            msk_q.push_back(24'h0);
            if (pat_dur[idx] == 8'd0) begin
                if (exp_q.size() < clr && idx != 0) begin
                    idx = 0;
                    continue;
                end
                break;
            end
            inc = pat_inc[idx];
            for (int c = 0; c < int'(pat_dur[idx]) * TD; c++) begin
                exp_q.push_back({1'b1, 4'(idx), inc, (inc != 16'd0), (c == 0), 1'b0});
                msk_q.push_back(24'h0);
            end
            for (int c = 0; c < GAPT * TD; c++) begin
                exp_q.push_back({1'b1, 4'(idx), inc, 3'b000});
                msk_q.push_back(24'h0);
            end
            if (idx == NS - 1) begin
                if (exp_q.size() < clr) begin
                    idx = 0;
                    continue;
                end
                break;
            end
            idx++;
        end
        exp_q.push_back({1'b0, 4'd0, inc, 3'b001});
        msk_q.push_back(IDXM);
        exp_q.push_back({1'b0, 4'd0, inc, 3'b000});
        msk_q.push_back(IDXM);
        cur_inc = inc;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (obs() !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs(), 24'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs(), 24'h0);
        end
        cur_inc = 16'd0;
    endtask

    task automatic test_single_note();
        write_step(0, 16'h0100, 8'd3);
        write_step(1, 16'h0000, 8'd0);
        build_trace(0);
        start   = 1'b1;
        loop_en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL single_note cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_rest_sequence();
        write_step(0, 16'h0200, 8'd1);
        write_step(1, 16'h0000, 8'd2);
        write_step(2, 16'h0300, 8'd1);
        write_step(3, 16'h0000, 8'd0);
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL rest_sequence cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_loop_wrap();
        int clr = 200;
        for (int a = 0; a < NS; a++) write_step(a, 16'h0100 + 16'(a), 8'd1);
        build_trace(clr);
        start   = 1'b1;
        loop_en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            loop_en = (i + 1 < clr);
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL loop_wrap cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
        loop_en = 1'b0;
    endtask

    task automatic test_stop_mid_note();
        write_step(0, 16'h0555, 8'd3);
        write_step(1, 16'h0666, 8'd1);
        write_step(2, 16'h0000, 8'd0);
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL stop_prefix cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            if (i < 5) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (obs() !== 24'h0) begin
            failures++;
            $display("[TB] FAIL stop_outputs: got %h expected %h", obs(), 24'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL stop_no_done: got busy,done=%b expected 00", {busy, done});
            end
        end
        cur_inc = 16'd0;
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL stop_replay cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_collisions();
        write_step(0, 16'h0123, 8'd2);
        write_step(1, 16'h0000, 8'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL start_stop_idle: got busy=%b expected 0", busy);
            end
            tick();
        end
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            start = (i + 1 == 4);
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL start_in_play cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
        start = 1'b0;
        write_step(0, 16'h0000, 8'd0);
        build_trace(1000);
        start   = 1'b1;
        loop_en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL zero_step0_loop cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        write_step(0, 16'h0400, 8'd2);
        write_step(1, 16'h0000, 8'd0);
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL reset_prefix cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            if (i < 10) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs() !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_in_gap: got %h expected %h", obs(), 24'h0);
        end
        cur_inc = 16'd0;
        build_trace(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                failures++;
                $display("[TB] FAIL reset_replay cycle %0d: got %h expected %h", i + 1, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int clr;
            for (int a = 0; a < NS; a++) begin
                write_step(a, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                           8'($urandom_range(0, 3)));
            end
            clr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 300)) : 0;
            build_trace(clr);
            start   = 1'b1;
            loop_en = (clr > 0);
            tick();
            start = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                loop_en = (i + 1 < clr);
                checks++;
                if ((obs() & ~msk_q[i]) !== (exp_q[i] & ~msk_q[i])) begin
                    failures++;
                    $display("[TB] FAIL random_%0d cycle %0d: got %h expected %h", r, i + 1, obs(), exp_q[i]);
                end
                tick();
            end
            loop_en = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 4'd0;
        cfg_data = 24'd0;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        cur_inc  = 16'd0;
        for (int a = 0; a < NS; a++) begin
            pat_inc[a] = 16'd0;
            pat_dur[a] = 8'd0;
        end
        test_reset();
        test_single_note();
        test_rest_sequence();
        test_loop_wrap();
        test_stop_mid_note();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
